// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_unit_if #(
  parameter int CNT_W = 16
) ();
  logic [3:0]       ID_RegRs;
  logic [3:0]       ID_RegRt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_MemWrite;
  logic             ID_BranchReg;
  logic             ID_BranchTaken;
  logic             EX_MemRead;
  logic             EX_RegWrite;
  logic [3:0]       EX_RegRd;
  logic             MEM_MemRead;
  logic [3:0]       MEM_RegRd;
  logic             DMem_busy;
  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_write;
  logic             ID_EX_bubble;
  logic             EX_MEM_write;
  logic             MEM_WB_write;
  logic [2:0]       hz_state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_RegRs, ID_RegRt, ID_UsesRs, ID_UsesRt, ID_MemWrite, ID_BranchReg,
           ID_BranchTaken, EX_MemRead, EX_RegWrite, EX_RegRd, MEM_MemRead,
           MEM_RegRd, DMem_busy,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
           EX_MEM_write, MEM_WB_write, hz_state, stall_cycles, flush_count
  );

  modport slave (
    input  ID_RegRs, ID_RegRt, ID_UsesRs, ID_UsesRt, ID_MemWrite, ID_BranchReg,
           ID_BranchTaken, EX_MemRead, EX_RegWrite, EX_RegRd, MEM_MemRead,
           MEM_RegRd, DMem_busy,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
           EX_MEM_write, MEM_WB_write, hz_state, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use/branch/memory-wait stall and flush controller
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_unit_if.slave hz
);
  typedef enum logic [2:0] {
    HZ_RUN  = 3'd0,
    HZ_LU   = 3'd1,
    HZ_BR   = 3'd2,
    HZ_MEMW = 3'd3,
    HZ_FL   = 3'd4
  } hz_cause_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_cause_e        cause;
  hz_cause_e        state_q;
  logic             lu_hit;
  logic             br_hit;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Store data (Rt of a store) is forwarded MEM-to-MEM, so it never stalls.
  always_comb begin
    lu_hit = hz.EX_MemRead && (hz.EX_RegRd != 4'd0) &&
             ((hz.ID_UsesRs && (hz.EX_RegRd == hz.ID_RegRs)) ||
              (hz.ID_UsesRt && !hz.ID_MemWrite && (hz.EX_RegRd == hz.ID_RegRt)));
    br_hit = hz.ID_BranchReg && (hz.ID_RegRs != 4'd0) &&
             ((hz.EX_RegWrite && (hz.EX_RegRd == hz.ID_RegRs)) ||
              (hz.MEM_MemRead && (hz.MEM_RegRd == hz.ID_RegRs)));
  end

  always_comb begin
    cause = HZ_RUN;
    if (hz.DMem_busy)          cause = HZ_MEMW;
    else if (lu_hit)           cause = HZ_LU;
    else if (br_hit)           cause = HZ_BR;
    else if (hz.ID_BranchTaken) cause = HZ_FL;
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    case (cause)
      HZ_MEMW: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
      end
      HZ_LU, HZ_BR: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      HZ_FL:   if_id_flush = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HZ_RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= cause;
      if (!pc_write && (stall_q != '1))
        stall_q <= stall_q + CNT_ONE;
      if (if_id_flush && (flush_q != '1))
        flush_q <= flush_q + CNT_ONE;
    end
  end

  assign hz.PC_write     = pc_write;
  assign hz.IF_ID_write  = if_id_write;
  assign hz.IF_ID_flush  = if_id_flush;
  assign hz.ID_EX_write  = id_ex_write;
  assign hz.ID_EX_bubble = id_ex_bubble;
  assign hz.EX_MEM_write = ex_mem_write;
  assign hz.MEM_WB_write = mem_wb_write;
  assign hz.hz_state     = state_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - randomized and directed bench for hazard_unit
module tb_hazard_unit;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;
  localparam int C_RUN = 0, C_LU = 1, C_BR = 2, C_MEMW = 3, C_FL = 4;
  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_write}
  localparam logic [6:0] K_RUN   = 7'b1101011;
  localparam logic [6:0] K_STALL = 7'b0001111;
  localparam logic [6:0] K_MEMW  = 7'b0000000;
  localparam logic [6:0] K_FL    = 7'b1111011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(CNT_W)) bus ();
  hazard_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hz(bus));

  logic [6:0] ctl;
  assign ctl = {bus.PC_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_write,
                bus.ID_EX_bubble, bus.EX_MEM_write, bus.MEM_WB_write};

  int checks = 0;
  int errors = 0;
  int exp_state, exp_stall, exp_flush;

  function automatic int model_cause();
    bit lu, br;
    lu = bus.EX_MemRead && bus.EX_RegRd != 0 &&
         ((bus.ID_UsesRs && bus.EX_RegRd == bus.ID_RegRs) ||
          (bus.ID_UsesRt && !bus.ID_MemWrite && bus.EX_RegRd == bus.ID_RegRt));
    br = bus.ID_BranchReg && bus.ID_RegRs != 0 &&
         ((bus.EX_RegWrite && bus.EX_RegRd == bus.ID_RegRs) ||
          (bus.MEM_MemRead && bus.MEM_RegRd == bus.ID_RegRs));
    if (bus.DMem_busy) return C_MEMW;
    if (lu) return C_LU;
    if (br) return C_BR;
    if (bus.ID_BranchTaken) return C_FL;
    return C_RUN;
  endfunction

  function automatic logic [6:0] model_ctl(int c);
    case (c)
      C_LU, C_BR: return K_STALL;
      C_MEMW:     return K_MEMW;
      C_FL:       return K_FL;
      default:    return K_RUN;
    endcase
  endfunction

  task automatic clear_inputs();
    bus.ID_RegRs = 0; bus.ID_RegRt = 0; bus.ID_UsesRs = 0; bus.ID_UsesRt = 0;
    bus.ID_MemWrite = 0; bus.ID_BranchReg = 0; bus.ID_BranchTaken = 0;
    bus.EX_MemRead = 0; bus.EX_RegWrite = 0; bus.EX_RegRd = 0;
    bus.MEM_MemRead = 0; bus.MEM_RegRd = 0; bus.DMem_busy = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_state = 0; exp_stall = 0; exp_flush = 0;
  endtask

  // Advance one clock, updating the reference state from the inputs now applied.
  task automatic tick();
    int c;
    logic [6:0] k;
    c = model_cause();
    k = model_ctl(c);
    exp_state = c;
    if (k[6] == 1'b0 && exp_stall < CMAX) exp_stall++;
    if (k[4] == 1'b1 && exp_flush < CMAX) exp_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #12;
    checks++; if (bus.hz_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.hz_state); end
    checks++; if (bus.stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", bus.stall_cycles); end
    checks++; if (bus.flush_count !== 4'd0) begin errors++; $display("FAIL reset_flush got %0d want 0", bus.flush_count); end
    checks++; if (ctl !== K_RUN) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, K_RUN); end
    @(negedge clk);
    rst = 1'b0;
    exp_state = 0; exp_stall = 0; exp_flush = 0;
  endtask

  task automatic test_load_use();
    do_reset();
    bus.EX_MemRead = 1; bus.EX_RegRd = 3; bus.ID_UsesRs = 1; bus.ID_RegRs = 3;
    #1;
    checks++; if (ctl !== K_STALL) begin errors++; $display("FAIL lu_ctl got %b want %b", ctl, K_STALL); end
    tick();
    checks++; if (bus.hz_state !== 3'd1) begin errors++; $display("FAIL lu_state got %0d want 1", bus.hz_state); end
    bus.EX_MemRead = 0;
    #1;
    checks++; if (ctl !== K_RUN) begin errors++; $display("FAIL lu_release_ctl got %b want %b", ctl, K_RUN); end
    tick();
    checks++; if (bus.hz_state !== 3'd0) begin errors++; $display("FAIL lu_state2 got %0d want 0", bus.hz_state); end
    checks++; if (bus.stall_cycles !== 4'd1) begin errors++; $display("FAIL lu_stall got %0d want 1", bus.stall_cycles); end
  endtask

  task automatic test_lu_exempt();
    do_reset();
    bus.EX_MemRead = 1; bus.EX_RegRd = 3;
    bus.ID_MemWrite = 1; bus.ID_UsesRt = 1; bus.ID_RegRt = 3; bus.ID_UsesRs = 0;
    #1;
    checks++; if (ctl !== K_RUN) begin errors++; $display("FAIL store_data_ctl got %b want %b", ctl, K_RUN); end
    bus.ID_MemWrite = 0;
    #1;
    checks++; if (ctl !== K_STALL) begin errors++; $display("FAIL rt_use_ctl got %b want %b", ctl, K_STALL); end
    bus.ID_UsesRt = 0; bus.EX_RegRd = 0; bus.ID_RegRs = 0; bus.ID_UsesRs = 1;
    #1;
    checks++; if (ctl !== K_RUN) begin errors++; $display("FAIL r0_ctl got %b want %b", ctl, K_RUN); end
    tick();
    checks++; if (bus.stall_cycles !== 4'd0) begin errors++; $display("FAIL r0_stall got %0d want 0", bus.stall_cycles); end
  endtask

  task automatic test_branch_reg();
    do_reset();
    bus.ID_BranchReg = 1; bus.ID_UsesRs = 1; bus.ID_RegRs = 5;
    bus.EX_RegWrite = 1; bus.EX_RegRd = 5;
    #1;
    checks++; if (ctl !== K_STALL) begin errors++; $display("FAIL br_ex_ctl got %b want %b", ctl, K_STALL); end
    tick();
    checks++; if (bus.hz_state !== 3'd2) begin errors++; $display("FAIL br_state1 got %0d want 2", bus.hz_state); end
    bus.EX_RegWrite = 0; bus.EX_RegRd = 0; bus.MEM_MemRead = 1; bus.MEM_RegRd = 5;
    #1;
    checks++; if (ctl !== K_STALL) begin errors++; $display("FAIL br_mem_ctl got %b want %b", ctl, K_STALL); end
    tick();
    checks++; if (bus.hz_state !== 3'd2) begin errors++; $display("FAIL br_state2 got %0d want 2", bus.hz_state); end
    bus.MEM_MemRead = 0; bus.ID_BranchTaken = 1;
    #1;
    checks++; if (ctl !== K_FL) begin errors++; $display("FAIL fl_ctl got %b want %b", ctl, K_FL); end
    tick();
    checks++; if (bus.hz_state !== 3'd4) begin errors++; $display("FAIL fl_state got %0d want 4", bus.hz_state); end
    checks++; if (bus.flush_count !== 4'd1) begin errors++; $display("FAIL fl_count got %0d want 1", bus.flush_count); end
    checks++; if (bus.stall_cycles !== 4'd2) begin errors++; $display("FAIL br_stall got %0d want 2", bus.stall_cycles); end
  endtask

  task automatic test_memw();
    do_reset();
    bus.DMem_busy = 1; bus.ID_BranchTaken = 1;
    bus.EX_MemRead = 1; bus.EX_RegRd = 7; bus.ID_UsesRs = 1; bus.ID_RegRs = 7;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== K_MEMW) begin errors++; $display("FAIL memw_ctl[%0d] got %b want %b", i, ctl, K_MEMW); end
      tick();
      checks++; if (bus.hz_state !== 3'd3) begin errors++; $display("FAIL memw_state[%0d] got %0d want 3", i, bus.hz_state); end
    end
    checks++; if (bus.stall_cycles !== 4'd3) begin errors++; $display("FAIL memw_stall got %0d want 3", bus.stall_cycles); end
    checks++; if (bus.flush_count !== 4'd0) begin errors++; $display("FAIL memw_flush got %0d want 0", bus.flush_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.DMem_busy = 1;
    for (int i = 0; i < 18; i++) tick();
    checks++; if (bus.stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_stall got %0d want 15", bus.stall_cycles); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.stall_cycles !== 4'd0 || bus.hz_state !== 3'd0 || bus.flush_count !== 4'd0)
      begin errors++; $display("FAIL async_rst got st=%0d sc=%0d fc=%0d want 0 0 0", bus.hz_state, bus.stall_cycles, bus.flush_count); end
    checks++; if (ctl !== K_MEMW) begin errors++; $display("FAIL rst_ctl got %b want %b", ctl, K_MEMW); end
    #1;
    rst = 1'b0;
    exp_state = 0; exp_stall = 0; exp_flush = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [6:0] k;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.ID_RegRs = 4'($urandom_range(0, 3)); bus.ID_RegRt = 4'($urandom_range(0, 3));
      bus.ID_UsesRs = 1'($urandom); bus.ID_UsesRt = 1'($urandom);
      bus.ID_MemWrite = 1'($urandom); bus.ID_BranchReg = 1'($urandom);
      bus.ID_BranchTaken = 1'($urandom);
      bus.EX_MemRead = 1'($urandom); bus.EX_RegWrite = 1'($urandom);
      bus.EX_RegRd = 4'($urandom_range(0, 3));
      bus.MEM_MemRead = 1'($urandom); bus.MEM_RegRd = 4'($urandom_range(0, 3));
      bus.DMem_busy = ($urandom_range(0, 4) == 0);
      #1;
      k = model_ctl(model_cause());
      checks++; if (ctl !== k) begin errors++; $display("FAIL rnd_ctl[%0d] got %b want %b", i, ctl, k); end
      tick();
      checks++; if (bus.hz_state !== 3'(exp_state)) begin errors++; $display("FAIL rnd_state[%0d] got %0d want %0d", i, bus.hz_state, exp_state); end
      checks++; if (bus.stall_cycles !== 4'(exp_stall) || bus.flush_count !== 4'(exp_flush))
        begin errors++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, bus.stall_cycles, bus.flush_count, exp_stall, exp_flush); end
      if (i == 199) begin
        do_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_lu_exempt();
    test_branch_reg();
    test_memw();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Hazard detection and stall/flush controller for the 5-stage pipeline. It resolves the hazards that EX/MEM/WB forwarding cannot: load-use, register-sourced branches in ID, taken-branch fetch flush and multi-cycle data-memory waits. It drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also keeps a registered hazard-state record and saturating stall and flush counters for performance debug.

Parameters:
CNT_W, 16, width of the stall_cycles and flush_count counters.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
ID_RegRs  input  4  source register 1 of the instruction in ID
ID_RegRt  input  4  source register 2 of the instruction in ID
ID_UsesRs  input  1  ID instruction reads Rs
ID_UsesRt  input  1  ID instruction reads Rt
ID_MemWrite  input  1  ID instruction is a store (Rt is store data)
ID_BranchReg  input  1  ID instruction is a register-target branch (reads Rs in ID)
ID_BranchTaken  input  1  branch in ID resolved taken this cycle
EX_MemRead  input  1  EX instruction is a load
EX_RegWrite  input  1  EX instruction writes a register
EX_RegRd  input  4  EX destination register
MEM_MemRead  input  1  MEM instruction is a load
MEM_RegRd  input  4  MEM destination register
DMem_busy  input  1  data memory has not completed its access this cycle
PC_write  output  1  PC update enable
IF_ID_write  output  1  IF/ID register enable
IF_ID_flush  output  1  load NOP into IF/ID
ID_EX_write  output  1  ID/EX register enable
ID_EX_bubble  output  1  load NOP (all control zero) into ID/EX
EX_MEM_write  output  1  EX/MEM register enable
MEM_WB_write  output  1  MEM/WB register enable
hz_state  output  3  registered cause of the previous cycle's action
stall_cycles  output  CNT_W  count of cycles with PC_write=0
flush_count  output  CNT_W  count of cycles with IF_ID_flush=1

Behaviour:
- Control outputs are combinational from the inputs (zero latency). hz_state and the counters are registered.
- Hazard causes (register 0 never causes a hazard):
  - LU: EX_MemRead & EX_RegRd!=0 & ((ID_UsesRs & EX_RegRd==ID_RegRs) | (ID_UsesRt & ~ID_MemWrite & EX_RegRd==ID_RegRt)). Store data from a load is not an LU hazard; MEM-to-MEM forwarding covers it.
  - BR: ID_BranchReg & ID_RegRs!=0 & ((EX_RegWrite & EX_RegRd==ID_RegRs) | (MEM_MemRead & MEM_RegRd==ID_RegRs)).
  - FL: ID_BranchTaken with no LU/BR.
- Priority: MEMW (DMem_busy) > LU > BR > FL > RUN.
- Defaults (RUN): all *_write=1, ID_EX_bubble=0, IF_ID_flush=0.
- MEMW: PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write all 0. No bubble, no flush. ID_BranchTaken is ignored and re-evaluated after the wait.
- LU and BR: PC_write=0, IF_ID_write=0, ID_EX_bubble=1. Downstream stages advance.
- FL: IF_ID_flush=1, all writes 1.
- hz_state encoding: 0 RUN, 1 LU, 2 BR, 3 MEMW, 4 FL. It loads the current cause every cycle.
- LU never holds for 2 consecutive cycles, because the bubble clears EX_MemRead. BR may persist until the producer leaves MEM.
- Counters:
  - stall_cycles increments on each cycle with PC_write=0.
  - flush_count increments on each cycle with IF_ID_flush=1.
  - Both saturate at all-ones (no wrap).
- Reset (async, any time, including mid-stall or mid-MEMW): hz_state=0 and both counters=0 immediately. Control outputs follow the inputs combinationally, independent of reset.

Test Plan:
1. Load r3 in EX (EX_MemRead=1, EX_RegRd=3), ID uses Rs=3 -> PC_write=0, IF_ID_write=0, ID_EX_bubble=1 for one cycle. Next cycle, with EX_MemRead=0, all controls return to RUN; hz_state reads 1 then 0; stall_cycles=1.
2. Same load, ID is a store with Rt=3 and ID_UsesRs=0 -> no stall. With EX_RegRd=0 and Rs=0 -> no stall.
3. ID_BranchReg with Rs=5, EX_RegWrite=1, EX_RegRd=5, then MEM_MemRead=1, MEM_RegRd=5 on the next cycle -> 2 stall cycles, then ID_BranchTaken=1 gives IF_ID_flush=1 for 1 cycle; flush_count=1, stall_cycles=2.
4. DMem_busy=1 for 3 cycles while LU and ID_BranchTaken are also true -> all write enables 0, no bubble, no flush; hz_state=3 for 3 cycles; stall_cycles=3.
5. Force stall_cycles to all-ones (CNT_W=4, 16 stall cycles) -> stays at 15. Assert rst mid-stall -> counters and hz_state read 0 before the next clock edge.
